// File: rtl/spi_tx_arbiter.sv
// Round-robin packet arbiter feeding one SPI output FIFO write port.
// Packets get a source-ID header; credits keep the FIFO from overfilling.
module spi_tx_arbiter #(
  parameter int          N       = 4,
  parameter int          CREDITS = 15,
  parameter logic [7:0]  HDR_TAG = 8'hA5,
  parameter int          TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [16*N-1:0] SRC_DATA,
  input  logic [N-1:0]    SRC_VALID,
  input  logic [N-1:0]    SRC_LAST,
  output logic [N-1:0]    SRC_READY,
  output logic [N-1:0]    GRANT,
  input  logic            TX_LOAD,
  output logic [15:0]     DATA,
  output logic            ENA,
  output logic [4:0]      CREDIT_CNT,
  output logic            ERR_TIMEOUT,
  output logic            ERR_CREDIT,
  input  logic            ERR_CLR
);

  localparam int         IW   = (N > 1) ? $clog2(N) : 1;
  localparam int         SW   = $clog2(TIMEOUT + 1);
  localparam logic [4:0] CMAX = 5'(CREDITS);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BURST
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   grant, grant_n;
  logic [IW-1:0]  ptr, ptr_n, win;
  logic           found;
  logic [4:0]     credit, avail;
  logic           has_cred;
  logic           tx_load_q, rise;
  logic [15:0]    data_q, data_n;
  logic           ena_q, ena_n;
  logic [SW-1:0]  stall, stall_n;
  logic           to_hit;
  logic           err_to, err_cr;
  logic           sel_valid, sel_last, accept;
  logic [15:0]    sel_data;

  assign rise     = TX_LOAD & ~tx_load_q;
  // A word already registered for ENA has consumed its credit.
  assign avail    = credit - {4'b0, ena_q};
  assign has_cred = avail != 5'd0;
  assign accept   = (state == BURST) && has_cred && sel_valid;

  assign SRC_READY   = (state == BURST && has_cred) ? grant : '0;
  assign GRANT       = grant;
  assign DATA        = data_q;
  assign ENA         = ena_q;
  assign CREDIT_CNT  = credit;
  assign ERR_TIMEOUT = err_to;
  assign ERR_CREDIT  = err_cr;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr == IW'(i)) begin
        sel_valid = SRC_VALID[i];
        sel_last  = SRC_LAST[i];
        sel_data  = SRC_DATA[16*i +: 16];
      end
    end
  end

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = ptr;
    for (int i = 1; i <= N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && SRC_VALID[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    ena_n   = 1'b0;
    data_n  = data_q;
    stall_n = stall;
    to_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        stall_n = '0;
        if (found) begin
          grant_n = {{(N-1){1'b0}}, 1'b1} << win;
          ptr_n   = win;
          state_n = HDR;
        end
      end
      HDR: begin
        if (has_cred) begin
          ena_n   = 1'b1;
          data_n  = {HDR_TAG, 4'h0, 4'(ptr)};
          stall_n = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          ena_n   = 1'b1;
          data_n  = sel_data;
          stall_n = '0;
          if (sel_last) begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else if (!sel_valid && has_cred) begin
          if (stall == SW'(TIMEOUT - 1)) begin
            to_hit  = 1'b1;
            grant_n = '0;
            stall_n = '0;
            state_n = IDLE;
          end else begin
            stall_n = stall + SW'(1);
          end
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= IW'(N - 1);
      data_q    <= '0;
      ena_q     <= 1'b0;
      stall     <= '0;
      tx_load_q <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      ptr       <= ptr_n;
      data_q    <= data_n;
      ena_q     <= ena_n;
      stall     <= stall_n;
      tx_load_q <= TX_LOAD;
    end
  end

  // Return at full count is held and flagged; simultaneous ENA nets to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credit <= CMAX;
      err_to <= 1'b0;
      err_cr <= 1'b0;
    end else begin
      if (ena_q && !rise) begin
        credit <= credit - 5'd1;
      end else if (rise && !ena_q && credit != CMAX) begin
        credit <= credit + 5'd1;
      end
      err_to <= to_hit | (err_to & ~ERR_CLR);
      err_cr <= (rise & ~ena_q & (credit == CMAX)) | (err_cr & ~ERR_CLR);
    end
  end

endmodule
